// File: rtl/state_timer_sel_if.sv
// Bundle between the controller FSM and the state timer: time constants,
// state-to-channel map and control strobes in, timer status out.
interface state_timer_sel_if #(
    parameter int WIDTH   = 19,
    parameter int NUM_CH  = 4,
    parameter int STATE_W = 4,
    parameter int CH_W    = 2
);
    logic [NUM_CH*WIDTH-1:0]      t_in;
    logic [(2**STATE_W)*CH_W-1:0] ch_map;
    logic [STATE_W-1:0]           present_state;
    logic                         tick;
    logic                         restart;
    logic [WIDTH-1:0]             tout;
    logic [WIDTH-1:0]             count;
    logic                         busy;
    logic                         expired;
    logic                         done;

    modport master (
        output t_in, ch_map, present_state, tick, restart,
        input  tout, count, busy, expired, done
    );

    modport slave (
        input  t_in, ch_map, present_state, tick, restart,
        output tout, count, busy, expired, done
    );
endinterface

// File: rtl/state_timer_sel.sv
// Per-state time-constant selector with a reloadable down-counter.
// Every state entry (or restart) loads the constant mapped to the new
// state; ticks count it down and expiry is reported as a pulse plus a level.
module state_timer_sel #(
    parameter int WIDTH   = 19,
    parameter int NUM_CH  = 4,
    parameter int STATE_W = 4,
    parameter int CH_W    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    state_timer_sel_if.slave  io
);
    localparam int NUM_ST = 2 ** STATE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cstate_t;

    cstate_t            state, state_nx;
    logic [CH_W-1:0]    ch_raw, ch;
    logic [WIDTH-1:0]   sel_val;
    logic [WIDTH-1:0]   tout_r;
    logic [WIDTH-1:0]   count_r, count_nx;
    logic               busy_r, busy_nx;
    logic               expired_r, expired_nx;
    logic               done_r, done_nx;
    logic [STATE_W-1:0] prev_state;
    logic               load;

    // Look up the channel assigned to the present controller state
    always_comb begin
        ch_raw = '0;
        for (int s = 0; s < NUM_ST; s++) begin
            if (io.present_state == STATE_W'(s))
                ch_raw = io.ch_map[s*CH_W +: CH_W];
        end
    end

    // Unpopulated channel indices fall back to channel 0, then pick the constant
    always_comb begin
        ch      = (32'(ch_raw) < NUM_CH) ? ch_raw : '0;
        sel_val = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ch == CH_W'(k))
                sel_val = io.t_in[k*WIDTH +: WIDTH];
        end
    end

    // IDLE only exists between reset and the first cycle, which must load
    // even if the controller happens to sit in the all-ones state.
    assign load = (io.present_state != prev_state) || io.restart || (state == IDLE);

    // Registered copy of the selected constant and the state seen last cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tout_r     <= '0;
            prev_state <= '1;
        end else begin
            tout_r     <= sel_val;
            prev_state <= io.present_state;
        end
    end

    // Counter FSM state register, including its registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count_r   <= '0;
            busy_r    <= 1'b0;
            expired_r <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state     <= state_nx;
            count_r   <= count_nx;
            busy_r    <= busy_nx;
            expired_r <= expired_nx;
            done_r    <= done_nx;
        end
    end

    // Counter FSM next-state: load dominates, then terminal tick in RUN
    always_comb begin
        state_nx = state;
        if (load) begin
            state_nx = (sel_val != '0) ? RUN : DONE;
        end else if (state == RUN && io.tick && count_r <= WIDTH'(1)) begin
            state_nx = DONE;
        end
    end

    // Counter FSM outputs; DONE with done low means the expiry pulse is still owed
    always_comb begin
        count_nx   = count_r;
        busy_nx    = busy_r;
        expired_nx = 1'b0;
        done_nx    = done_r;
        if (load) begin
            count_nx = sel_val;
            busy_nx  = (sel_val != '0);
            done_nx  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (io.tick) begin
                        if (count_r > WIDTH'(1)) begin
                            count_nx = count_r - WIDTH'(1);
                        end else begin
                            count_nx   = '0;
                            busy_nx    = 1'b0;
                            expired_nx = 1'b1;
                            done_nx    = 1'b1;
                        end
                    end
                end
                DONE: begin
                    count_nx = '0;
                    busy_nx  = 1'b0;
                    if (!done_r) begin
                        expired_nx = 1'b1;
                        done_nx    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign io.tout    = tout_r;
    assign io.count   = count_r;
    assign io.busy    = busy_r;
    assign io.expired = expired_r;
    assign io.done    = done_r;
endmodule

// File: tb/tb_state_timer_sel.sv
// Scoreboard bench for state_timer_sel: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_state_timer_sel;
    localparam int W  = 19;
    localparam int NC = 3;
    localparam int SW = 4;
    localparam int CW = 2;

    typedef struct {
        logic [W-1:0] tout;
        logic [W-1:0] count;
        logic         busy;
        logic         expired;
        logic         done;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    exp_t sb[$];

    // behavioural model state
    logic [W-1:0]  m_count;
    logic [W-1:0]  m_tout;
    logic          m_busy, m_exp, m_done, m_pending, m_first;
    logic [SW-1:0] m_prev;

    state_timer_sel_if #(.WIDTH(W), .NUM_CH(NC), .STATE_W(SW), .CH_W(CW)) bus ();

    state_timer_sel #(.WIDTH(W), .NUM_CH(NC), .STATE_W(SW), .CH_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_sel(input logic [SW-1:0] ps);
        int c;
        c = int'(bus.ch_map[int'(ps)*CW +: CW]);
        if (c >= NC) c = 0;
        return bus.t_in[c*W +: W];
    endfunction

    task automatic set_ch(input int k, input logic [W-1:0] v);
        bus.t_in[k*W +: W] = v;
    endtask

    task automatic set_map(input int s, input logic [CW-1:0] c);
        bus.ch_map[s*CW +: CW] = c;
    endtask

    task automatic model_reset();
        m_count = '0; m_tout = '0; m_busy = 0; m_exp = 0; m_done = 0;
        m_pending = 0; m_first = 1; m_prev = '1;
    endtask

    // Apply inputs for the coming rising edge and record what it must produce.
    task automatic drive(input logic [SW-1:0] ps, input logic tk, input logic rs);
        logic [W-1:0] v;
        exp_t e;
        bus.present_state = ps;
        bus.tick          = tk;
        bus.restart       = rs;
        v      = ref_sel(ps);
        m_tout = v;
        m_exp  = 0;
        if (m_first || ps != m_prev || rs) begin
            m_count   = v;
            m_done    = 0;
            m_busy    = (v != 0);
            m_pending = (v == 0);
        end else if (m_pending) begin
            m_pending = 0;
            m_exp     = 1;
            m_done    = 1;
        end else if (m_busy && tk) begin
            m_count = m_count - 1;
            if (m_count == 0) begin
                m_busy = 0;
                m_exp  = 1;
                m_done = 1;
            end
        end
        m_first = 0;
        m_prev  = ps;
        e.tout = m_tout; e.count = m_count; e.busy = m_busy;
        e.expired = m_exp; e.done = m_done;
        sb.push_back(e);
    endtask

    task automatic step(input logic [SW-1:0] ps, input logic tk, input logic rs);
        drive(ps, tk, rs);
        @(negedge clk);
    endtask

    // Monitor: the DUT presents a fresh status word after every rising edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("tout",    32'(bus.tout),    32'(e.tout));
                chk("count",   32'(bus.count),   32'(e.count));
                chk("busy",    32'(bus.busy),    32'(e.busy));
                chk("expired", 32'(bus.expired), 32'(e.expired));
                chk("done",    32'(bus.done),    32'(e.done));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        logic [SW-1:0] ps;
        checks = 0;
        failures = 0;
        model_reset();
        rst_n = 1'b0;
        bus.present_state = '0;
        bus.tick = 0;
        bus.restart = 0;
        bus.t_in = '0;
        bus.ch_map = {16{2'd1}};
        set_ch(1, 19'd5);
        #3;
        chk("rst_tout",    32'(bus.tout),    0);
        chk("rst_count",   32'(bus.count),   0);
        chk("rst_busy",    32'(bus.busy),    0);
        chk("rst_expired", 32'(bus.expired), 0);
        chk("rst_done",    32'(bus.done),    0);

        // all states on ch1=5: forced load after reset, then 5 ticks to expiry
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 0);

        // state 0 -> ch0=3, state 3 -> ch2=7; leave state 0 mid-count
        set_map(0, 2'd0); set_map(3, 2'd2);
        set_ch(0, 19'd3); set_ch(2, 19'd7);
        step(0, 0, 1);
        step(0, 1, 0);
        step(3, 0, 0);
        step(3, 1, 0);
        step(3, 1, 0);

        // state change with a tick in the same cycle: load of 4 wins
        set_map(5, 2'd1); set_ch(1, 19'd4);
        step(5, 1, 0);
        for (int i = 0; i < 5; i++) step(5, 1, 0);

        // zero constant: immediate expiry without a tick, then ticks ignored
        set_ch(1, 19'd0); set_map(6, 2'd1);
        step(6, 0, 0);
        for (int i = 0; i < 3; i++) step(6, 1, 0);

        // unpopulated channel 3 falls back to ch0; restart held with ticks
        set_map(7, 2'd3); set_ch(0, 19'd9);
        step(7, 1, 0);
        for (int i = 0; i < 3; i++) step(7, 1, 1);
        step(7, 1, 0);
        step(7, 1, 0);

        // asynchronous reset mid-run at count=2, then reload on release
        set_map(8, 2'd2); set_ch(2, 19'd5);
        step(8, 0, 0);
        for (int i = 0; i < 3; i++) step(8, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tout",    32'(bus.tout),    0);
        chk("arst_count",   32'(bus.count),   0);
        chk("arst_busy",    32'(bus.busy),    0);
        chk("arst_expired", 32'(bus.expired), 0);
        chk("arst_done",    32'(bus.done),    0);
        sb.delete();
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(8, 0, 0);
        step(8, 1, 0);

        // randomized traffic over a handful of states
        ps = 4'd8;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0)
                set_ch($urandom_range(0, NC - 1),
                       ($urandom_range(0, 29) == 0) ? W'($urandom) : W'($urandom_range(0, 6)));
            if ($urandom_range(0, 9) == 0)
                set_map($urandom_range(0, 3), CW'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0)
                ps = SW'($urandom_range(0, 3));
            step(ps, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
        end

        @(posedge clk);
        #2;
        chk("sb_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/state_timer_sel.md
Name: state_timer_sel

Overview:
- Parametrised successor to the train controller's two-input time-constant selector.
- Holds NUM_CH time constants, each WIDTH bits wide. A programmable per-state map selects one constant for each controller FSM state.
- On every state entry, or on an explicit restart, the selected constant loads into an internal down-counter. The counter decrements on an enable tick, and the block raises a registered timeout toward the controller FSM.

Parameters:
- WIDTH, 19, bit width of each time constant and of the counter.
- NUM_CH, 4, number of time-constant channels (2..16).
- STATE_W, 4, width of the controller state code; the map holds 2**STATE_W entries.
- CH_W, 2, channel index width; must satisfy 2**CH_W >= NUM_CH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- t_in  input  NUM_CH*WIDTH  packed time constants; channel k occupies bits [k*WIDTH +: WIDTH].
- ch_map  input  (2**STATE_W)*CH_W  packed state-to-channel map; entry s occupies bits [s*CH_W +: CH_W].
- present_state  input  STATE_W  current controller FSM state.
- tick  input  1  count-enable strobe, one cycle wide (e.g. prescaled 1 ms).
- restart  input  1  reload the counter from the current state's channel.
- tout  output  WIDTH  registered selected constant for the current state.
- count  output  WIDTH  current counter value.
- busy  output  1  high while the counter is non-zero and counting.
- expired  output  1  one-cycle pulse when the counter reaches 0.
- done  output  1  level; high from expiry until the next load.

Behaviour:
- Reset (async, rst_n=0):
  - tout=0, count=0, busy=0, expired=0, done=0.
  - prev_state register = all ones, which forces a load on the first cycle after reset.
- Channel select (combinational):
  - ch = ch_map entry [present_state].
  - If ch >= NUM_CH, channel 0 is used.
  - sel_val = t_in channel ch.
- tout register: updates every cycle to sel_val. Latency is 1 cycle from present_state, t_in or ch_map change.
- load condition: (present_state != prev_state) OR restart. prev_state <= present_state every cycle.
- Counter FSM, three states (IDLE, RUN, DONE). The sequence below is evaluated each cycle in priority order:
  1. If load:
     - count <= sel_val, expired <= 0, done <= 0.
     - If sel_val != 0, go to RUN with busy=1.
     - If sel_val == 0, go to DONE: expired <= 1 next cycle (one pulse), then done=1.
  2. RUN with tick, count > 1: count <= count-1.
  3. RUN with tick, count == 1: count <= 0, busy <= 0, expired <= 1 (1 cycle), done <= 1, go to DONE.
  4. RUN without tick: hold.
  5. DONE: hold count=0, done=1, expired=0 after its single pulse. No wrap-around; further ticks are ignored.
  6. IDLE: only reachable from reset before the first load; the first post-reset cycle performs the load.
- Simultaneous events:
  - load and tick in the same cycle: load wins and the tick is discarded.
  - restart together with a state change: a single load.
  - restart held high: reloads every cycle, so the counter never advances.
- Arithmetic: unsigned, WIDTH bits; decrement never underflows.
- Mid-operation changes:
  - A t_in or ch_map change mid-run does not affect count until the next load. tout still tracks the change after 1 cycle.
  - Reset asserted mid-run clears all outputs immediately (asynchronously). The counter restarts via the forced load after deassertion.

Test Plan:
- Reset then map all states to ch1, t_in ch1=5, state=0 -> cycle after reset: count=5, busy=1, tout=5; after 5 ticks count=0, expired pulses exactly once, done=1, busy=0.
- State 0 maps to ch0=3, state 3 maps to ch2=7. Switch state 0->3 after 1 tick -> next cycle count=7, done=0, tout=7; expired never fires for state 0.
- Load and tick in the same cycle (state change with tick=1), ch value 4 -> count=4, not 3; 4 further ticks are needed for expiry.
- Selected value 0 -> done=1 and a single expired pulse with no tick needed. Ticks in DONE keep count=0 and expired=0.
- ch_map entry = 3 with NUM_CH=3 -> falls back to ch0. restart held 3 cycles with ticks active -> count stays at the loaded value.
- rst_n low mid-run at count=2 -> all outputs 0 immediately. After release, count reloads from the current state.
